// File: rtl/shortest_path_grid.sv
// Grid shortest-path engine: walks a ROWS x COLS cost matrix in row-major order,
// writing saturating cumulative minimum cost (L) and direction codes (P) to SRAM.
module shortest_path_grid #(
  parameter int D_WIDTH = 8,
  parameter int A_WIDTH = 13,
  parameter int ROWS    = 4,
  parameter int COLS    = 4,
  parameter int RD_LAT  = 1,
  parameter logic [D_WIDTH-1:0] P_START = 'h08,
  parameter logic [D_WIDTH-1:0] P_RIGHT = 'h09,
  parameter logic [D_WIDTH-1:0] P_DOWN  = 'h0A
) (
  input  logic               Clk,
  input  logic               Rst,
  input  logic               Go,
  input  logic [D_WIDTH-1:0] M_In,
  input  logic [D_WIDTH-1:0] L_In,
  output logic [A_WIDTH-1:0] M_Addr,
  output logic [A_WIDTH-1:0] L_Addr,
  output logic [A_WIDTH-1:0] P_Addr,
  output logic               M_En,
  output logic               M_Rw,
  output logic               L_En,
  output logic               L_Rw,
  output logic               P_En,
  output logic               P_Rw,
  output logic [D_WIDTH-1:0] L_Out,
  output logic [D_WIDTH-1:0] P_Out,
  output logic               Done,
  output logic               Busy,
  output logic [D_WIDTH-1:0] Cost,
  output logic               Sat
);

  localparam logic [A_WIDTH-1:0] LAST_ROW = A_WIDTH'(ROWS - 1);
  localparam logic [A_WIDTH-1:0] LAST_COL = A_WIDTH'(COLS - 1);
  localparam logic [A_WIDTH-1:0] COLS_A   = A_WIDTH'(COLS);
  localparam logic [A_WIDTH-1:0] ONE_A    = A_WIDTH'(1);
  localparam logic [2:0]         LAT      = 3'(RD_LAT);

  typedef enum logic [3:0] {IDLE, ADDR, RDU, WU, RDL, WL, CMP, WM, WR} state_t;

  state_t             state;
  logic [A_WIDTH-1:0] row, col, addr0, addr_up, addr_left;
  logic [D_WIDTH-1:0] lu, ll, mv;
  logic [2:0]         wcnt;
  logic               sel_up, sel_left;

  logic               top, left, last, take_up, take_left;
  logic [D_WIDTH-1:0] code, operand, result;
  logic [D_WIDTH:0]   sum;

  always_comb begin
    top       = (row == '0);
    left      = (col == '0);
    last      = (row == LAST_ROW) && (col == LAST_COL);
    // Edge cells have a single predecessor; interior ties resolve to Right.
    take_up   = !top && (left || (lu < ll));
    take_left = !left && !take_up;
    if (top && left) code = P_START;
    else if (take_up) code = P_DOWN;
    else code = P_RIGHT;
    operand = '0;
    if (sel_up) operand = lu;
    else if (sel_left) operand = ll;
    sum    = {1'b0, mv} + {1'b0, operand};
    result = sum[D_WIDTH] ? '1 : sum[D_WIDTH-1:0];
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state <= IDLE;
      row <= '0; col <= '0; addr0 <= '0; addr_up <= '0; addr_left <= '0;
      lu <= '0; ll <= '0; mv <= '0; wcnt <= '0; sel_up <= 1'b0; sel_left <= 1'b0;
      M_Addr <= '0; L_Addr <= '0; P_Addr <= '0;
      M_En <= 1'b0; M_Rw <= 1'b0; L_En <= 1'b0; L_Rw <= 1'b0; P_En <= 1'b0; P_Rw <= 1'b0;
      L_Out <= '0; P_Out <= '0; Done <= 1'b0; Busy <= 1'b0; Cost <= '0; Sat <= 1'b0;
    end else begin
      M_Addr <= '0; L_Addr <= '0; P_Addr <= '0;
      M_En <= 1'b0; M_Rw <= 1'b0; L_En <= 1'b0; L_Rw <= 1'b0; P_En <= 1'b0; P_Rw <= 1'b0;
      L_Out <= '0; P_Out <= '0; Done <= 1'b0;
      unique case (state)
        IDLE: begin
          Busy <= 1'b0;
          if (Go) begin
            Busy  <= 1'b1;
            Sat   <= 1'b0;
            Cost  <= '0;
            row   <= '0;
            col   <= '0;
            addr0 <= '0;
            state <= ADDR;
          end
        end
        ADDR: begin
          addr_up   <= addr0 - COLS_A;
          addr_left <= addr0 - ONE_A;
          if (top && left) state <= CMP;
          else if (top) state <= RDL;
          else state <= RDU;
        end
        RDU: begin
          L_En   <= 1'b1;
          L_Addr <= addr_up;
          wcnt   <= '0;
          state  <= WU;
        end
        WU: begin
          if (wcnt == LAT) begin
            lu    <= L_In;
            state <= left ? CMP : RDL;
          end else begin
            wcnt <= wcnt + 3'd1;
          end
        end
        RDL: begin
          L_En   <= 1'b1;
          L_Addr <= addr_left;
          wcnt   <= '0;
          state  <= WL;
        end
        WL: begin
          if (wcnt == LAT) begin
            ll    <= L_In;
            state <= CMP;
          end else begin
            wcnt <= wcnt + 3'd1;
          end
        end
        CMP: begin
          M_En     <= 1'b1;
          M_Addr   <= addr0;
          P_En     <= 1'b1;
          P_Rw     <= 1'b1;
          P_Addr   <= addr0;
          P_Out    <= code;
          sel_up   <= take_up;
          sel_left <= take_left;
          wcnt     <= '0;
          state    <= WM;
        end
        WM: begin
          if (wcnt == LAT) begin
            mv    <= M_In;
            state <= WR;
          end else begin
            wcnt <= wcnt + 3'd1;
          end
        end
        WR: begin
          L_En   <= 1'b1;
          L_Rw   <= 1'b1;
          L_Addr <= addr0;
          L_Out  <= result;
          if (sum[D_WIDTH]) Sat <= 1'b1;
          if (last) begin
            Done  <= 1'b1;
            Cost  <= result;
            state <= IDLE;
          end else begin
            if (col == LAST_COL) begin
              col <= '0;
              row <= row + ONE_A;
            end else begin
              col <= col + ONE_A;
            end
            addr0 <= addr0 + ONE_A;
            state <= ADDR;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_shortest_path_grid.sv
// Bench for shortest_path_grid: four geometries, SRAM models with exact read latency,
// and a dynamic-programming reference model for L, P, saturation and cycle timing.
module tb_shortest_path_grid;
  localparam int NI = 4;
  localparam int ROWS_T[NI] = '{2, 1, 4, 1};
  localparam int COLS_T[NI] = '{2, 2, 4, 1};
  localparam int LAT_T[NI]  = '{1, 1, 3, 1};
  localparam logic [7:0] BASIC_L[4] = '{8'd1, 8'd3, 8'd4, 8'd7};
  localparam logic [7:0] BASIC_P[4] = '{8'h08, 8'h09, 8'h0A, 8'h0A};

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        go[NI], clr[NI];
  logic [7:0]  m_in[NI], l_in[NI], l_out[NI], p_out[NI], cost[NI];
  logic [12:0] m_addr[NI], l_addr[NI], p_addr[NI];
  logic        m_en[NI], m_rw[NI], l_en[NI], l_rw[NI], p_en[NI], p_rw[NI];
  logic        done[NI], busy[NI], sat[NI];
  logic [7:0]  m_src[NI][16], lm[NI][16], pm[NI][16], mp[NI][4], lp[NI][4];

  shortest_path_grid #(.ROWS(2), .COLS(2), .RD_LAT(1)) u_a (
    .Clk(clk), .Rst(rst), .Go(go[0]), .M_In(m_in[0]), .L_In(l_in[0]),
    .M_Addr(m_addr[0]), .L_Addr(l_addr[0]), .P_Addr(p_addr[0]),
    .M_En(m_en[0]), .M_Rw(m_rw[0]), .L_En(l_en[0]), .L_Rw(l_rw[0]), .P_En(p_en[0]), .P_Rw(p_rw[0]),
    .L_Out(l_out[0]), .P_Out(p_out[0]), .Done(done[0]), .Busy(busy[0]), .Cost(cost[0]), .Sat(sat[0]));
  shortest_path_grid #(.ROWS(1), .COLS(2), .RD_LAT(1)) u_b (
    .Clk(clk), .Rst(rst), .Go(go[1]), .M_In(m_in[1]), .L_In(l_in[1]),
    .M_Addr(m_addr[1]), .L_Addr(l_addr[1]), .P_Addr(p_addr[1]),
    .M_En(m_en[1]), .M_Rw(m_rw[1]), .L_En(l_en[1]), .L_Rw(l_rw[1]), .P_En(p_en[1]), .P_Rw(p_rw[1]),
    .L_Out(l_out[1]), .P_Out(p_out[1]), .Done(done[1]), .Busy(busy[1]), .Cost(cost[1]), .Sat(sat[1]));
  shortest_path_grid #(.ROWS(4), .COLS(4), .RD_LAT(3)) u_c (
    .Clk(clk), .Rst(rst), .Go(go[2]), .M_In(m_in[2]), .L_In(l_in[2]),
    .M_Addr(m_addr[2]), .L_Addr(l_addr[2]), .P_Addr(p_addr[2]),
    .M_En(m_en[2]), .M_Rw(m_rw[2]), .L_En(l_en[2]), .L_Rw(l_rw[2]), .P_En(p_en[2]), .P_Rw(p_rw[2]),
    .L_Out(l_out[2]), .P_Out(p_out[2]), .Done(done[2]), .Busy(busy[2]), .Cost(cost[2]), .Sat(sat[2]));
  shortest_path_grid #(.ROWS(1), .COLS(1), .RD_LAT(1)) u_d (
    .Clk(clk), .Rst(rst), .Go(go[3]), .M_In(m_in[3]), .L_In(l_in[3]),
    .M_Addr(m_addr[3]), .L_Addr(l_addr[3]), .P_Addr(p_addr[3]),
    .M_En(m_en[3]), .M_Rw(m_rw[3]), .L_En(l_en[3]), .L_Rw(l_rw[3]), .P_En(p_en[3]), .P_Rw(p_rw[3]),
    .L_Out(l_out[3]), .P_Out(p_out[3]), .Done(done[3]), .Busy(busy[3]), .Cost(cost[3]), .Sat(sat[3]));

  // SRAM models: read data is valid only in the cycle exactly LAT after the En cycle.
  always @(posedge clk) begin
    for (int k = 0; k < NI; k++) begin
      for (int s = 3; s > 0; s--) begin
        mp[k][s] <= mp[k][s-1];
        lp[k][s] <= lp[k][s-1];
      end
      mp[k][0] <= (m_en[k] && !m_rw[k]) ? m_src[k][m_addr[k][3:0]] : 8'($urandom);
      lp[k][0] <= (l_en[k] && !l_rw[k]) ? lm[k][l_addr[k][3:0]] : 8'($urandom);
      if (clr[k]) begin
        for (int a = 0; a < 16; a++) begin
          lm[k][a] <= 8'($urandom);
          pm[k][a] <= 8'hFF;
        end
      end else begin
        if (l_en[k] && l_rw[k]) lm[k][l_addr[k][3:0]] <= l_out[k];
        if (p_en[k] && p_rw[k]) pm[k][p_addr[k][3:0]] <= p_out[k];
      end
    end
  end

  always_comb begin
    for (int k = 0; k < NI; k++) begin
      m_in[k] = mp[k][LAT_T[k]-1];
      l_in[k] = lp[k][LAT_T[k]-1];
    end
  end

  int checks = 0;
  int failures = 0;

  int o_done, o_done_cnt, o_bfirst, o_blast, o_lwc, o_pwc, o_post_wr;
  int o_lw[16];
  logic [7:0] o_cost_done, o_cost_end, o_cost_c1;
  logic o_sat_done, o_sat_end, o_sat_c1;
  logic [71:0] o_rst_outs;

  int e_l[16], e_p[16], e_lw[16];
  int e_n, e_sat;

  function automatic logic [71:0] outs(input int k);
    return {m_addr[k], l_addr[k], p_addr[k], m_en[k], m_rw[k], l_en[k], l_rw[k], p_en[k], p_rw[k],
            l_out[k], p_out[k], done[k], busy[k], cost[k], sat[k]};
  endfunction

  // Dynamic-programming reference: values, directions, and cycle at which each L write appears.
  task automatic model(input int k);
    int r, c, lat, t, s, a;
    r = ROWS_T[k]; c = COLS_T[k]; lat = LAT_T[k]; t = 0; e_sat = 0;
    for (int i = 0; i < r; i++) begin
      for (int j = 0; j < c; j++) begin
        a = i * c + j;
        if (i == 0 && j == 0) begin
          e_p[a] = 8'h08; s = m_src[k][a]; t += lat + 4;
        end else if (i == 0) begin
          e_p[a] = 8'h09; s = m_src[k][a] + e_l[a-1]; t += 2 * lat + 6;
        end else if (j == 0) begin
          e_p[a] = 8'h0A; s = m_src[k][a] + e_l[a-c]; t += 2 * lat + 6;
        end else begin
          t += 3 * lat + 8;
          if (e_l[a-c] < e_l[a-1]) begin
            e_p[a] = 8'h0A; s = m_src[k][a] + e_l[a-c];
          end else begin
            e_p[a] = 8'h09; s = m_src[k][a] + e_l[a-1];
          end
        end
        if (s > 255) begin
          s = 255; e_sat = 1;
        end
        e_l[a] = s;
        e_lw[a] = t + 1;
      end
    end
    e_n = t;
  endtask

  task automatic run(input int k, input int limit, input int go_mid, input int rst_at);
    int g, rel, lim;
    @(negedge clk); clr[k] = 1'b1;
    @(negedge clk); clr[k] = 1'b0;
    o_done = 0; o_done_cnt = 0; o_bfirst = 0; o_blast = 0; o_lwc = 0; o_pwc = 0; o_post_wr = 0;
    o_rst_outs = '1;
    for (int a = 0; a < 16; a++) o_lw[a] = -1;
    go[k] = 1'b1; g = int'(cyc); rel = 0; lim = limit;
    while (rel < lim) begin
      @(negedge clk);
      rel = int'(cyc) - g;
      if (rel == 1) begin
        go[k] = 1'b0; o_cost_c1 = cost[k]; o_sat_c1 = sat[k];
      end
      if (go_mid > 0 && rel == go_mid) go[k] = 1'b1;
      if (go_mid > 0 && rel == go_mid + 1) go[k] = 1'b0;
      if (rst_at > 0 && rel == rst_at) rst = 1'b1;
      if (rst_at > 0 && rel == rst_at + 1) begin
        rst = 1'b0; o_rst_outs = outs(k);
      end
      if (l_en[k] && l_rw[k]) begin
        o_lwc++; o_lw[l_addr[k][3:0]] = rel;
      end
      if (p_en[k] && p_rw[k]) o_pwc++;
      if (rst_at > 0 && rel > rst_at && ((l_en[k] && l_rw[k]) || (p_en[k] && p_rw[k]))) o_post_wr++;
      if (busy[k]) begin
        if (o_bfirst == 0) o_bfirst = rel;
        o_blast = rel;
      end
      if (done[k]) begin
        o_done_cnt++;
        if (o_done == 0) begin
          o_done = rel; o_cost_done = cost[k]; o_sat_done = sat[k]; lim = rel + 4;
        end
      end
    end
    o_cost_end = cost[k]; o_sat_end = sat[k];
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < NI; k++) begin
      checks++;
      if (outs(k) !== '0) begin
        failures++; $display("FAIL reset_outputs inst=%0d got=%h exp=0", k, outs(k));
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_basic_2x2;
    m_src[0][0] = 8'd1; m_src[0][1] = 8'd2; m_src[0][2] = 8'd3; m_src[0][3] = 8'd4;
    run(0, 80, 0, 0);
    for (int a = 0; a < 4; a++) begin
      checks++;
      if (lm[0][a] !== BASIC_L[a]) begin
        failures++; $display("FAIL basic_L cell=%0d got=%0d exp=%0d", a, lm[0][a], BASIC_L[a]);
      end
      checks++;
      if (pm[0][a] !== BASIC_P[a]) begin
        failures++; $display("FAIL basic_P cell=%0d got=%h exp=%h", a, pm[0][a], BASIC_P[a]);
      end
    end
    checks++;
    if (o_done !== 33 || o_done_cnt !== 1) begin
      failures++; $display("FAIL basic_done cycle=%0d count=%0d exp cycle=33 count=1", o_done, o_done_cnt);
    end
    checks++;
    if (o_cost_done !== 8'd7 || o_cost_end !== 8'd7) begin
      failures++; $display("FAIL basic_cost at_done=%0d held=%0d exp=7", o_cost_done, o_cost_end);
    end
    checks++;
    if (o_sat_done !== 1'b0) begin
      failures++; $display("FAIL basic_sat got=%0b exp=0", o_sat_done);
    end
    checks++;
    if (o_bfirst !== 1 || o_blast !== 33) begin
      failures++; $display("FAIL basic_busy first=%0d last=%0d exp 1..33", o_bfirst, o_blast);
    end
    checks++;
    if (o_lwc !== 4 || o_pwc !== 4) begin
      failures++; $display("FAIL basic_write_count L=%0d P=%0d exp=4/4", o_lwc, o_pwc);
    end
  endtask

  task automatic test_tie;
    m_src[0][0] = 8'd1; m_src[0][1] = 8'd5; m_src[0][2] = 8'd5; m_src[0][3] = 8'd1;
    model(0);
    run(0, 80, 0, 0);
    checks++;
    if (pm[0][3] !== 8'h09) begin
      failures++; $display("FAIL tie_P got=%h exp=09", pm[0][3]);
    end
    checks++;
    if (lm[0][3] !== 8'd7 || lm[0][3] !== 8'(e_l[3])) begin
      failures++; $display("FAIL tie_L got=%0d exp=7 model=%0d", lm[0][3], e_l[3]);
    end
  endtask

  task automatic test_saturation;
    m_src[1][0] = 8'd200; m_src[1][1] = 8'd100;
    run(1, 60, 0, 0);
    checks++;
    if (lm[1][1] !== 8'd255 || lm[1][0] !== 8'd200) begin
      failures++; $display("FAIL sat_L got=%0d,%0d exp=200,255", lm[1][0], lm[1][1]);
    end
    checks++;
    if (pm[1][0] !== 8'h08 || pm[1][1] !== 8'h09) begin
      failures++; $display("FAIL sat_P got=%h,%h exp=08,09", pm[1][0], pm[1][1]);
    end
    checks++;
    if (o_sat_done !== 1'b1 || o_cost_done !== 8'd255) begin
      failures++; $display("FAIL sat_flag sat=%0b cost=%0d exp sat=1 cost=255", o_sat_done, o_cost_done);
    end
    repeat (6) @(negedge clk);
    checks++;
    if (sat[1] !== 1'b1) begin
      failures++; $display("FAIL sat_held got=%0b exp=1", sat[1]);
    end
    m_src[1][0] = 8'd3; m_src[1][1] = 8'd4;
    run(1, 60, 0, 0);
    checks++;
    if (o_sat_c1 !== 1'b0 || o_cost_c1 !== 8'd0) begin
      failures++; $display("FAIL sat_clear_on_go sat=%0b cost=%0d exp 0/0", o_sat_c1, o_cost_c1);
    end
    checks++;
    if (o_sat_done !== 1'b0 || lm[1][1] !== 8'd7 || o_cost_done !== 8'd7) begin
      failures++; $display("FAIL sat_rerun sat=%0b L=%0d cost=%0d exp 0/7/7", o_sat_done, lm[1][1], o_cost_done);
    end
  endtask

  task automatic test_random_4x4;
    for (int it = 0; it < 6; it++) begin
      for (int a = 0; a < 16; a++)
        m_src[2][a] = (it < 3) ? 8'($urandom_range(0, 40)) : 8'($urandom_range(0, 255));
      model(2);
      run(2, e_n + 40, 0, 0);
      for (int a = 0; a < 16; a++) begin
        checks++;
        if (lm[2][a] !== 8'(e_l[a]) || pm[2][a] !== 8'(e_p[a])) begin
          failures++;
          $display("FAIL rand_cell it=%0d cell=%0d got L=%0d P=%h exp L=%0d P=%h", it, a, lm[2][a], pm[2][a], e_l[a], e_p[a]);
        end
        checks++;
        if (o_lw[a] !== e_lw[a]) begin
          failures++; $display("FAIL rand_cell_timing it=%0d cell=%0d got=%0d exp=%0d", it, a, o_lw[a], e_lw[a]);
        end
      end
      checks++;
      if (o_done !== e_n + 1 || o_cost_done !== 8'(e_l[15]) || o_sat_done !== 1'(e_sat)) begin
        failures++;
        $display("FAIL rand_done it=%0d cyc=%0d cost=%0d sat=%0b exp %0d/%0d/%0d", it, o_done, o_cost_done, o_sat_done, e_n + 1, e_l[15], e_sat);
      end
      checks++;
      if (o_bfirst !== 1 || o_blast !== e_n + 1) begin
        failures++; $display("FAIL rand_busy it=%0d first=%0d last=%0d exp 1..%0d", it, o_bfirst, o_blast, e_n + 1);
      end
      if (it == 0) begin
        checks++;
        if (o_lw[0] !== 8 || o_lw[1] - o_lw[0] !== 12 || o_lw[5] - o_lw[4] !== 17) begin
          failures++;
          $display("FAIL rand_cell_counts got=%0d/%0d/%0d exp=7/12/17", o_lw[0] - 1, o_lw[1] - o_lw[0], o_lw[5] - o_lw[4]);
        end
      end
    end
  endtask

  task automatic test_go_ignored;
    for (int a = 0; a < 16; a++) m_src[2][a] = 8'($urandom_range(0, 50));
    model(2);
    run(2, e_n + 40, 45, 0);
    checks++;
    if (o_done !== e_n + 1 || o_done_cnt !== 1) begin
      failures++; $display("FAIL go_ignored_done cyc=%0d count=%0d exp %0d/1", o_done, o_done_cnt, e_n + 1);
    end
    for (int a = 0; a < 16; a++) begin
      checks++;
      if (lm[2][a] !== 8'(e_l[a]) || pm[2][a] !== 8'(e_p[a])) begin
        failures++; $display("FAIL go_ignored_cell cell=%0d got L=%0d P=%h exp L=%0d P=%h", a, lm[2][a], pm[2][a], e_l[a], e_p[a]);
      end
    end
  endtask

  task automatic test_rst_mid;
    for (int a = 0; a < 16; a++) m_src[2][a] = 8'($urandom_range(0, 60));
    run(2, 100, 0, 55);
    checks++;
    if (o_rst_outs !== '0) begin
      failures++; $display("FAIL rst_mid_outputs got=%h exp=0", o_rst_outs);
    end
    checks++;
    if (o_post_wr !== 0 || o_done_cnt !== 0) begin
      failures++; $display("FAIL rst_mid_quiet writes=%0d done=%0d exp 0/0", o_post_wr, o_done_cnt);
    end
    model(2);
    run(2, e_n + 40, 0, 0);
    checks++;
    if (o_done !== e_n + 1 || o_cost_done !== 8'(e_l[15])) begin
      failures++; $display("FAIL rst_rerun_done cyc=%0d cost=%0d exp %0d/%0d", o_done, o_cost_done, e_n + 1, e_l[15]);
    end
    for (int a = 0; a < 16; a++) begin
      checks++;
      if (lm[2][a] !== 8'(e_l[a]) || pm[2][a] !== 8'(e_p[a])) begin
        failures++; $display("FAIL rst_rerun_cell cell=%0d got L=%0d P=%h exp L=%0d P=%h", a, lm[2][a], pm[2][a], e_l[a], e_p[a]);
      end
    end
  endtask

  task automatic test_1x1;
    m_src[3][0] = 8'd42;
    run(3, 40, 0, 0);
    checks++;
    if (o_done !== 6 || o_lw[0] !== 6) begin
      failures++; $display("FAIL one_cell_done cyc=%0d lwrite=%0d exp=6/6", o_done, o_lw[0]);
    end
    checks++;
    if (o_lwc !== 1 || o_pwc !== 1) begin
      failures++; $display("FAIL one_cell_writes L=%0d P=%0d exp=1/1", o_lwc, o_pwc);
    end
    checks++;
    if (lm[3][0] !== 8'd42 || pm[3][0] !== 8'h08 || o_cost_done !== 8'd42) begin
      failures++; $display("FAIL one_cell_values L=%0d P=%h cost=%0d exp 42/08/42", lm[3][0], pm[3][0], o_cost_done);
    end
  endtask

  initial begin
    for (int k = 0; k < NI; k++) begin
      go[k] = 1'b0;
      clr[k] = 1'b0;
      for (int a = 0; a < 16; a++) m_src[k][a] = 8'd0;
    end
    test_reset();
    test_basic_2x2();
    test_tie();
    test_saturation();
    test_random_4x4();
    test_go_ignored();
    test_rst_mid();
    test_1x1();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout time=%0t limit=2000000", $time);
    $fatal(1, "global timeout");
  end

endmodule
